// File: rtl/jacobi_pair_scheduler_pkg.sv
// Shared constants and types for the Jacobi eigen-solver pair scheduler.
package jacobi_pair_scheduler_pkg;

    localparam int unsigned JACOBI_N        = 8;
    localparam int unsigned JACOBI_N_ROUNDS = JACOBI_N - 1;
    localparam int unsigned JACOBI_IDX_W    = $clog2(JACOBI_N);

    typedef struct packed {
        logic [JACOBI_IDX_W-1:0] p;
        logic [JACOBI_IDX_W-1:0] q;
    } jacobi_pair_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} jacobi_sched_state_t;

endpackage

// File: rtl/jacobi_pair_scheduler_if.sv
// Pair issue / rotation completion channel between the scheduler and the CORDIC datapath.
interface jacobi_pair_scheduler_if
    import jacobi_pair_scheduler_pkg::*;
#(
    parameter int unsigned IDX_W = JACOBI_IDX_W
);
    logic             pair_valid;
    logic             pair_ready;
    logic [IDX_W-1:0] pair_p;
    logic [IDX_W-1:0] pair_q;
    logic             pair_last;
    logic             rot_done;

    modport master (
        output pair_valid, pair_p, pair_q, pair_last,
        input  pair_ready, rot_done
    );

    modport slave (
        input  pair_valid, pair_p, pair_q, pair_last,
        output pair_ready, rot_done
    );
endinterface

// File: rtl/jacobi_pair_gen.sv
// Circle-method (round-robin) pair generator: (round, pair index) -> ordered (p, q).
module jacobi_pair_gen #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N),
    parameter int unsigned RND_W = $clog2(N - 1)
) (
    input  logic [RND_W-1:0] round_idx,
    input  logic [IDX_W-1:0] pair_cnt,
    output logic [IDX_W-1:0] p,
    output logic [IDX_W-1:0] q
);

    // Position 0 is fixed; positions 1..N-1 rotate by round_idx modulo N-1.
    function automatic logic [IDX_W-1:0] player(input logic [IDX_W-1:0] pos,
                                                 input logic [RND_W-1:0] rnd);
        logic [IDX_W:0] t;
        if (pos == '0) return '0;
        t = (IDX_W+1)'(pos) - (IDX_W+1)'(1) + (IDX_W+1)'(rnd);
        if (t >= (IDX_W+1)'(N - 1)) t = t - (IDX_W+1)'(N - 1);
        t = t + (IDX_W+1)'(1);
        return t[IDX_W-1:0];
    endfunction

    logic [IDX_W-1:0] pos_b;
    logic [IDX_W-1:0] pl_a;
    logic [IDX_W-1:0] pl_b;

    always_comb begin
        pos_b = IDX_W'(N - 1) - pair_cnt;
        pl_a  = player(pair_cnt, round_idx);
        pl_b  = player(pos_b, round_idx);
        p     = (pl_a < pl_b) ? pl_a : pl_b;
        q     = (pl_a < pl_b) ? pl_b : pl_a;
    end

endmodule

// File: rtl/jacobi_pair_scheduler.sv
// Issues the disjoint rotation pairs of each Jacobi round, draining rotations between rounds.
module jacobi_pair_scheduler
    import jacobi_pair_scheduler_pkg::*;
#(
    parameter int unsigned N        = JACOBI_N,
    parameter int unsigned N_SWEEPS = 6,
    parameter int unsigned IDX_W    = $clog2(N),
    localparam int unsigned RND_W   = $clog2(N - 1),
    localparam int unsigned SWP_W   = $clog2(N_SWEEPS + 1),
    localparam int unsigned OUT_W   = $clog2(N / 2 + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    jacobi_pair_scheduler_if.master pif,
    output logic [RND_W-1:0]        round_idx,
    output logic [SWP_W-1:0]        sweep_idx,
    output logic                    busy,
    output logic                    job_done,
    output logic                    err
);

    jacobi_sched_state_t state_q, state_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [SWP_W-1:0] sweep_q, sweep_d;
    logic [IDX_W-1:0] pair_cnt_q, pair_cnt_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic             err_q, err_d;
    logic             valid, hs, last, err_set;
    logic [IDX_W-1:0] gen_p, gen_q;

    jacobi_pair_gen #(
        .N     (N),
        .IDX_W (IDX_W),
        .RND_W (RND_W)
    ) u_pair_gen (
        .round_idx (round_q),
        .pair_cnt  (pair_cnt_q),
        .p         (gen_p),
        .q         (gen_q)
    );

    assign valid   = (state_q == ISSUE);
    assign hs      = valid & pif.pair_ready;
    assign last    = (pair_cnt_q == IDX_W'(N / 2 - 1));
    assign err_set = pif.rot_done & ~hs & (outst_q == '0);

    // Pair fields are gated so every output reads zero outside ISSUE.
    assign pif.pair_valid = valid;
    assign pif.pair_p     = valid ? gen_p : '0;
    assign pif.pair_q     = valid ? gen_q : '0;
    assign pif.pair_last  = valid & last;

    assign round_idx = round_q;
    assign sweep_idx = sweep_q;
    assign busy      = (state_q != IDLE);
    assign job_done  = (state_q == DONE);
    assign err       = err_q;

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        sweep_d    = sweep_q;
        pair_cnt_d = pair_cnt_q;
        outst_d    = outst_q;
        err_d      = err_q | err_set;

        if (hs && !pif.rot_done) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (!hs && pif.rot_done && outst_q != '0) begin
            outst_d = outst_q - OUT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ISSUE;
                    round_d    = '0;
                    sweep_d    = '0;
                    pair_cnt_d = '0;
                    outst_d    = '0;
                    err_d      = 1'b0;
                end
            end
            ISSUE: begin
                if (hs) begin
                    pair_cnt_d = pair_cnt_q + IDX_W'(1);
                    if (last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // outst_d already accounts for a rot_done arriving this cycle.
                if (outst_d == '0) begin
                    pair_cnt_d = '0;
                    if (round_q < RND_W'(N - 2)) begin
                        round_d = round_q + RND_W'(1);
                        state_d = ISSUE;
                    end else if (sweep_q < SWP_W'(N_SWEEPS - 1)) begin
                        sweep_d = sweep_q + SWP_W'(1);
                        round_d = '0;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                round_d    = '0;
                sweep_d    = '0;
                pair_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            round_d    = '0;
            sweep_d    = '0;
            pair_cnt_d = '0;
            outst_d    = '0;
            err_d      = err_q | err_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            round_q    <= '0;
            sweep_q    <= '0;
            pair_cnt_q <= '0;
            outst_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            sweep_q    <= sweep_d;
            pair_cnt_q <= pair_cnt_d;
            outst_q    <= outst_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_jacobi_pair_scheduler.sv
// Scoreboard bench: expected pair stream queued at job start, popped on each handshake.
module tb_jacobi_pair_scheduler;
    import jacobi_pair_scheduler_pkg::*;

    localparam int unsigned N     = 8;
    localparam int unsigned NS    = 2;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned RND_W = $clog2(N - 1);
    localparam int unsigned SWP_W = $clog2(NS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [RND_W-1:0] round_idx;
    logic [SWP_W-1:0] sweep_idx;
    logic             busy;
    logic             job_done;
    logic             err;

    always #5 clk = ~clk;

    jacobi_pair_scheduler_if #(.IDX_W(IDX_W)) pif ();

    jacobi_pair_scheduler #(
        .N        (N),
        .N_SWEEPS (NS),
        .IDX_W    (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pif       (pif),
        .round_idx (round_idx),
        .sweep_idx (sweep_idx),
        .busy      (busy),
        .job_done  (job_done),
        .err       (err)
    );

    typedef struct {
        int p;
        int q;
        int last;
        int round;
        int sweep;
    } exp_t;

    exp_t sb[$];
    int   due[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc = 0, hs_cnt = 0, jd_cnt = 0, bubble_cnt = 0;
    int   pair_seen[N][N];
    int   rd_mode = 0;       // 0: rot_done 3 cycles after handshake, 1: same cycle
    logic late_mode = 1'b0;
    int   late_cyc = -1, first_r1_cyc = -1;
    int   stray_n = 0, stray_done = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference ordering: rotate players 1..N-1 left by one position per round.
    task automatic push_job();
        int   arr[N];
        int   tmp, a, b;
        exp_t e;
        for (int s = 0; s < NS; s++) begin
            for (int i = 0; i < N; i++) arr[i] = i;
            for (int r = 0; r < N - 1; r++) begin
                for (int k = 0; k < N / 2; k++) begin
                    a       = arr[k];
                    b       = arr[N-1-k];
                    e.p     = (a < b) ? a : b;
                    e.q     = (a < b) ? b : a;
                    e.last  = (k == N / 2 - 1) ? 1 : 0;
                    e.round = r;
                    e.sweep = s;
                    sb.push_back(e);
                end
                tmp = arr[1];
                for (int i = 1; i < N - 1; i++) arr[i] = arr[i+1];
                arr[N-1] = tmp;
            end
        end
    endtask

    // Monitor and rotation-datapath model; samples on the falling edge.
    initial begin
        logic jd_prev;
        logic hs, rd;
        exp_t e;
        int   dly;
        jd_prev      = 1'b0;
        pif.rot_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            hs = pif.pair_valid && pif.pair_ready && !abort;
            rd = 1'b0;
            if (rst || abort) due.delete();
            if (jd_prev) check_eq("busy_after_done", busy, 0);
            jd_prev = job_done;
            if (job_done) jd_cnt++;
            if (busy && !pif.pair_valid && !job_done) bubble_cnt++;
            if (late_mode && pif.pair_valid && round_idx == 1 && sweep_idx == 0 &&
                first_r1_cyc < 0) first_r1_cyc = cyc;
            if (hs) begin
                hs_cnt++;
                pair_seen[pif.pair_p][pif.pair_q]++;
                dly = 3;
                check_eq("pair_expected", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("pair_p", pif.pair_p, e.p);
                    check_eq("pair_q", pif.pair_q, e.q);
                    check_eq("pair_last", pif.pair_last, e.last);
                    check_eq("round_idx", round_idx, e.round);
                    check_eq("sweep_idx", sweep_idx, e.sweep);
                    if (late_mode && e.last == 1 && e.round == 0 && e.sweep == 0) dly = 10;
                end
                if (rd_mode == 1) rd = 1'b1;
                else begin
                    due.push_back(cyc + dly);
                    if (dly == 10) late_cyc = cyc + dly;
                end
            end
            if (!rd) begin
                for (int i = 0; i < due.size(); i++) begin
                    if (due[i] <= cyc) begin
                        rd = 1'b1;
                        due.delete(i);
                        break;
                    end
                end
            end
            if (stray_n != stray_done) begin
                rd = 1'b1;
                stray_done++;
            end
            pif.rot_done = rd;
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        push_job();
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!job_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done_seen"}, job_done, 1);
        @(negedge clk);
    endtask

    task automatic do_abort();
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        sb.delete();
    endtask

    initial begin
        int hs0, jd0, b0, n;
        rst            = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        pif.pair_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", pif.pair_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_job_done", job_done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_round", round_idx, 0);
        check_eq("rst_sweep", sweep_idx, 0);
        check_eq("rst_pair_q", pif.pair_q, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full job, ready high, rot_done 3 cycles after each handshake.
        pif.pair_ready = 1'b1;
        hs0 = hs_cnt;
        jd0 = jd_cnt;
        pulse_start();
        check_eq("start_latency_valid", pif.pair_valid, 1);
        wait_done("job1");
        check_eq("job1_pairs", hs_cnt - hs0, NS * (N - 1) * (N / 2));
        check_eq("job1_done_pulses", jd_cnt - jd0, 1);
        check_eq("job1_sb_empty", sb.size(), 0);
        for (int p = 0; p < N; p++)
            for (int q = p + 1; q < N; q++)
                check_eq($sformatf("pair_once_per_sweep_%0d_%0d", p, q), pair_seen[p][q], NS);

        // Backpressure on the first pair.
        pif.pair_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_valid", pif.pair_valid, 1);
            check_eq("hold_p", pif.pair_p, 0);
            check_eq("hold_q", pif.pair_q, 7);
        end
        @(posedge clk);
        #1 pif.pair_ready = 1'b1;
        wait_done("job2");

        // rot_done in the same cycle as every handshake: one DRAIN cycle per round.
        rd_mode = 1;
        b0  = bubble_cnt;
        hs0 = hs_cnt;
        pulse_start();
        wait_done("job3");
        check_eq("job3_drain_cycles", bubble_cnt - b0, NS * (N - 1));
        check_eq("job3_pairs", hs_cnt - hs0, NS * (N - 1) * (N / 2));
        check_eq("job3_err", err, 0);
        rd_mode = 0;

        // Withhold the last rotation of round 0 for 10 cycles.
        late_mode = 1'b1;
        pulse_start();
        n = 0;
        while (first_r1_cyc < 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("late_round1_cycle", first_r1_cyc, late_cyc + 1);
        wait_done("job4");
        late_mode = 1'b0;

        // Abort in ISSUE of round 3, coincident with a handshake.
        jd0 = jd_cnt;
        pulse_start();
        n = 0;
        while (!(pif.pair_valid && round_idx == 3) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_reached_round3", round_idx, 3);
        do_abort();
        @(negedge clk);
        check_eq("abort_valid", pif.pair_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_round", round_idx, 0);
        repeat (5) @(negedge clk);
        check_eq("abort_no_job_done", jd_cnt - jd0, 0);
        check_eq("abort_err", err, 0);
        pulse_start();
        wait_done("job5");

        // Stray rot_done while idle sets a sticky error; start clears it.
        @(posedge clk);
        #1 stray_n++;
        repeat (2) @(negedge clk);
        check_eq("stray_err_set", err, 1);
        do_abort();
        repeat (4) @(negedge clk);
        check_eq("stray_err_sticky", err, 1);
        pulse_start();
        @(negedge clk);
        check_eq("start_clears_err", err, 0);
        do_abort();

        // Asynchronous reset mid-job.
        pulse_start();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_valid", pif.pair_valid, 0);
        check_eq("async_rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
